// File: rtl/conway_pkg.sv
// ============================================================================
// conway_pkg: shared FSM state type, default grid size, cell index helper.  Rev 1.0
// ============================================================================
`default_nettype none

package conway_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_HEIGHT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Flat bit position of cell (r,c) in a row-major grid vector.
  function automatic int idx(input int r, input int c, input int width);
    return r * width + c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conway_gen_fsm.sv
// ============================================================================
// conway_gen_fsm: run control, remaining-step counter and generation counter.
// Option: CONWAY_STABLE_DETECT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module conway_gen_fsm
  import conway_pkg::*;
#(
  parameter int GEN_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_valid,
  input  logic [GEN_CNT_W-1:0] run_gens,
  input  logic                 wr_commit,
`ifdef CONWAY_STABLE_DETECT_EN
  input  logic                 grid_stable,
  output logic                 stable,
`endif
  output logic                 run_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 step,
  output logic [GEN_CNT_W-1:0] gen_count
);

  state_t               state, state_nx;
  logic [GEN_CNT_W-1:0] remaining;
  logic                 accept;
`ifdef CONWAY_STABLE_DETECT_EN
  logic                 stable_hit;
`endif

  assign accept    = run_valid && (state == IDLE);
  assign run_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_comb begin
    state_nx   = state;
    step       = 1'b0;
`ifdef CONWAY_STABLE_DETECT_EN
    stable_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (run_gens == '0) state_nx = DONE;
`ifdef CONWAY_STABLE_DETECT_EN
          // A same-cycle write changes the grid, so stability is judged in RUN instead.
          else if (grid_stable && !wr_commit) begin
            state_nx   = DONE;
            stable_hit = 1'b1;
          end
`endif
          else state_nx = RUN;
        end
      end
      RUN: begin
`ifdef CONWAY_STABLE_DETECT_EN
        if (grid_stable) begin
          state_nx   = DONE;
          stable_hit = 1'b1;
        end else
`endif
        begin
          step = 1'b1;
          if (remaining == GEN_CNT_W'(1)) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      gen_count <= '0;
`ifdef CONWAY_STABLE_DETECT_EN
      stable    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept)    remaining <= run_gens;
      else if (step) remaining <= remaining - GEN_CNT_W'(1);
      if (wr_commit) gen_count <= '0;
      else if (step) gen_count <= gen_count + GEN_CNT_W'(1);
`ifdef CONWAY_STABLE_DETECT_EN
      stable <= stable_hit;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/conway_gen_engine.sv
// ============================================================================
// conway_gen_engine: grid register, host row access and run sequencing for the
// Conway next-state stage.  Option: CONWAY_STABLE_DETECT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module conway_gen_engine
  import conway_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int HEIGHT    = DEF_HEIGHT,
  parameter  int GEN_CNT_W = 16,
  localparam int ROW_W     = $clog2(HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ROW_W-1:0]        wr_row,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [ROW_W-1:0]        rd_row,
  output logic [WIDTH-1:0]        rd_data,
  input  logic                    run_valid,
  output logic                    run_ready,
  input  logic [GEN_CNT_W-1:0]    run_gens,
  output logic                    busy,
  output logic                    done,
  output logic [GEN_CNT_W-1:0]    gen_count,
`ifdef CONWAY_STABLE_DETECT_EN
  output logic                    stable,
`endif
  output logic [WIDTH*HEIGHT-1:0] grid_states,
  input  logic [WIDTH*HEIGHT-1:0] next_states
);

  logic [WIDTH-1:0] rows [HEIGHT];
  logic             wr_commit;
  logic             rd_ok;
  logic             step;

  // Writes land only while idle; out-of-range rows are dropped.
  assign wr_commit = wr_en && run_ready && ({1'b0, wr_row} < (ROW_W+1)'(HEIGHT));
  assign rd_ok     = ({1'b0, rd_row} < (ROW_W+1)'(HEIGHT));

  for (genvar r = 0; r < HEIGHT; r++) begin : g_rows
    logic [WIDTH-1:0] row_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     row_q <= '0;
      else if (wr_commit && wr_row == ROW_W'(r))   row_q <= wr_data;
      else if (step)                               row_q <= next_states[idx(r, 0, WIDTH) +: WIDTH];
    end

    assign rows[r]                                 = row_q;
    assign grid_states[idx(r, 0, WIDTH) +: WIDTH]  = row_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_ok ? rows[rd_row] : '0;
  end

  conway_gen_fsm #(
    .GEN_CNT_W (GEN_CNT_W)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .run_valid   (run_valid),
    .run_gens    (run_gens),
    .wr_commit   (wr_commit),
`ifdef CONWAY_STABLE_DETECT_EN
    .grid_stable (next_states == grid_states),
    .stable      (stable),
`endif
    .run_ready   (run_ready),
    .busy        (busy),
    .done        (done),
    .step        (step),
    .gen_count   (gen_count)
  );

endmodule

`default_nettype wire
